// File: rtl/mem_req_agent.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_agent
// Purpose  : Buffers master commands, arbitrates for the shared memory bus and
//            issues one command per grant; tracks read returns with a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_agent #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              req,
    input  logic              grant,
    output logic              mem_cmd_valid,
    output logic              mem_cmd_we,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [DATA_W-1:0] mem_cmd_wdata,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_TO_W  = $clog2(TIMEOUT);

    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
    localparam logic [c_TO_W-1:0]  c_TO_LAST = c_TO_W'(TIMEOUT - 1);

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_REQ     = 3'd1;
    localparam logic [2:0] c_S_ISSUE   = 3'd2;
    localparam logic [2:0] c_S_WAIT_RD = 3'd3;
    localparam logic [2:0] c_S_RESP    = 3'd4;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_TO_W-1:0]  r_tcnt;

    logic              r_fifo_we    [DEPTH];
    logic [ADDR_W-1:0] r_fifo_addr  [DEPTH];
    logic [DATA_W-1:0] r_fifo_wdata [DEPTH];

    logic w_push;
    logic w_pop;
    logic w_nonempty;

    assign cmd_ready  = !rst && (r_count != c_FULL);
    assign w_push     = cmd_valid && cmd_ready;
    assign w_pop      = (r_state == c_S_REQ) && grant;
    assign w_nonempty = (r_count != '0);
    assign busy       = (r_state != c_S_IDLE) || w_nonempty;

    // Storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_we[r_wr_ptr]    <= cmd_we;
            r_fifo_addr[r_wr_ptr]  <= cmd_addr;
            r_fifo_wdata[r_wr_ptr] <= cmd_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_S_IDLE;
            r_tcnt        <= '0;
            req           <= 1'b0;
            mem_cmd_valid <= 1'b0;
            mem_cmd_we    <= 1'b0;
            mem_cmd_addr  <= '0;
            mem_cmd_wdata <= '0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
        end else begin
            // Bus fields default to zero so several agents can be OR-combined.
            mem_cmd_valid <= 1'b0;
            mem_cmd_we    <= 1'b0;
            mem_cmd_addr  <= '0;
            mem_cmd_wdata <= '0;
            rsp_valid     <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_nonempty) begin
                        r_state <= c_S_REQ;
                        req     <= 1'b1;
                    end
                end
                c_S_REQ: begin
                    if (grant) begin
                        r_state       <= c_S_ISSUE;
                        req           <= 1'b0;
                        mem_cmd_valid <= 1'b1;
                        mem_cmd_we    <= r_fifo_we[r_rd_ptr];
                        mem_cmd_addr  <= r_fifo_addr[r_rd_ptr];
                        mem_cmd_wdata <= r_fifo_wdata[r_rd_ptr];
                    end
                end
                c_S_ISSUE: begin
                    // mem_cmd_we still holds the issued command's direction here.
                    if (!mem_cmd_we) begin
                        r_state <= c_S_WAIT_RD;
                        r_tcnt  <= '0;
                    end else if (w_nonempty) begin
                        r_state <= c_S_REQ;
                        req     <= 1'b1;
                    end else begin
                        r_state <= c_S_IDLE;
                    end
                end
                c_S_WAIT_RD: begin
                    if (mem_rd_valid) begin
                        r_state   <= c_S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= mem_rd_data;
                        rsp_err   <= 1'b0;
                    end else if (r_tcnt == c_TO_LAST) begin
                        r_state   <= c_S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + c_TO_W'(1);
                    end
                end
                c_S_RESP: begin
                    if (w_nonempty) begin
                        r_state <= c_S_REQ;
                        req     <= 1'b1;
                    end else begin
                        r_state <= c_S_IDLE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                    req     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
